// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared constants and helpers for the pipelined adder
package pipe_adder_pkg;

    // Operation select carried on the sub input.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Bit positions of the condition flags in the ALU status word.
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_W = 3;

    // Width of one carry-linked segment; WIDTH must divide evenly by STAGES.
    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// rtl/pipe_adder_seg.sv - one segment adder with carry-in and carry-out
module pipe_adder_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    // Plain ripple within the segment; the segment is short enough to close timing.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined add/subtract unit with valid/ready handshake
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    // Stage registers: operands travel forward so later stages find their
    // segment, the partial result accumulates one segment per stage.
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] r_q;
    logic [STAGES-1:0]            c_q;
    logic [STAGES-1:0]            v_q;
    logic [FLAG_W-1:0]            flags_q;

    // Inputs seen by each stage (external operands for stage 0).
    logic [STAGES-1:0][WIDTH-1:0] a_src;
    logic [STAGES-1:0][WIDTH-1:0] b_src;
    logic [STAGES-1:0][WIDTH-1:0] r_src;
    logic [STAGES-1:0]            c_src;
    logic [STAGES-1:0]            v_src;

    logic [STAGES-1:0][SEG-1:0]   seg_sum;
    logic [STAGES-1:0]            seg_co;
    logic [STAGES-1:0][WIDTH-1:0] r_nxt;
    logic [FLAG_W-1:0]            flags_nxt;
    logic [WIDTH-1:0]             b_in;
    logic                         stall;
    logic                         unused_bits;

    // A held result freezes the whole pipe; nothing may enter behind it.
    assign stall    = v_q[LAST] & ~out_ready;
    assign in_ready = ~stall;

    // Subtraction is op1 + ~op2 + 1, the +1 entering as stage 0 carry-in.
    assign b_in = (sub == OP_SUB) ? ~op2 : op2;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : gen_stage
            if (k == 0) begin : gen_head
                assign a_src[0] = op1;
                assign b_src[0] = b_in;
                assign r_src[0] = '0;
                assign c_src[0] = sub;
                assign v_src[0] = in_valid & in_ready;
            end else begin : gen_link
                assign a_src[k] = a_q[k-1];
                assign b_src[k] = b_q[k-1];
                assign r_src[k] = r_q[k-1];
                assign c_src[k] = c_q[k-1];
                assign v_src[k] = v_q[k-1];
            end

            pipe_adder_seg #(
                .SEG (SEG)
            ) u_seg (
                .a    (a_src[k][k*SEG +: SEG]),
                .b    (b_src[k][k*SEG +: SEG]),
                .cin  (c_src[k]),
                .sum  (seg_sum[k]),
                .cout (seg_co[k])
            );
        end
    endgenerate

    // Merge each stage's new segment into the partial result it forwards.
    always_comb begin
        r_nxt = r_src;
        for (int i = 0; i < STAGES; i++) begin
            r_nxt[i][i*SEG +: SEG] = seg_sum[i];
        end
    end

    // Flags come from the complete result formed in the last stage.
    always_comb begin
        flags_nxt         = '0;
        flags_nxt[FLAG_C] = seg_co[LAST];
        flags_nxt[FLAG_V] = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1]) &&
                            (r_nxt[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);
        flags_nxt[FLAG_Z] = (r_nxt[LAST] == '0);
    end

    // Operand bits a stage no longer needs, and the last-stage carry copy,
    // are left for synthesis to prune.
    assign unused_bits = ^{a_src, b_src, c_q[LAST]};

    // Pipeline advance: every stage moves together unless the output is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            v_q     <= '0;
            flags_q <= '0;
        end else if (!stall) begin
            a_q     <= a_src;
            b_q     <= b_src;
            r_q     <= r_nxt;
            c_q     <= seg_co;
            v_q     <= v_src;
            flags_q <= flags_nxt;
        end
    end

    assign out_valid = v_q[LAST];
    assign out       = r_q[LAST];
    assign carry     = flags_q[FLAG_C];
    assign overflow  = flags_q[FLAG_V];
    assign zero      = flags_q[FLAG_Z];

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboard bench for pipe_adder at STAGES 4, 1 and 32
module tb_pipe_adder;

    logic        clk;
    logic        rst_n;

    logic        v4, rdy4, vo4, ordy4, s4, c4, ovf4, z4;
    logic [31:0] a4, b4, o4;

    logic        sw_v, sw_s;
    logic [31:0] sw_a, sw_b;
    logic        rdy1, vo1, c1, ovf1, z1;
    logic [31:0] o1;
    logic        rdy32, vo32, c32, ovf32, z32;
    logic [31:0] o32;
    logic        always_ready;

    logic [34:0] q4[$];
    logic [34:0] q1[$];
    logic [34:0] q32[$];
    logic [34:0] e4, e1, e32;

    int passed = 0;
    int total  = 0;
    int del4   = 0;

    pipe_adder #(.WIDTH(32), .STAGES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
        .op1(a4), .op2(b4), .sub(s4), .out_valid(vo4), .out_ready(ordy4),
        .out(o4), .carry(c4), .overflow(ovf4), .zero(z4)
    );

    pipe_adder #(.WIDTH(32), .STAGES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_v), .in_ready(rdy1),
        .op1(sw_a), .op2(sw_b), .sub(sw_s), .out_valid(vo1), .out_ready(always_ready),
        .out(o1), .carry(c1), .overflow(ovf1), .zero(z1)
    );

    pipe_adder #(.WIDTH(32), .STAGES(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_v), .in_ready(rdy32),
        .op1(sw_a), .op2(sw_b), .sub(sw_s), .out_valid(vo32), .out_ready(always_ready),
        .out(o32), .carry(c32), .overflow(ovf32), .zero(z32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: full-width arithmetic, packed as {zero, overflow, carry, out}.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] bb;
        logic [32:0] full;
        logic        ov;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, s};
        ov   = (a[31] == bb[31]) && (full[31] != a[31]);
        return {(full[31:0] == 32'd0), ov, full[32], full[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboards: push on accept, pop and compare on delivery (sampled mid-cycle).
    always @(negedge clk) begin
        if (rst_n) begin
            if (vo4 && ordy4) begin
                if (q4.size() == 0) begin
                    chk("u4_unexpected_result", 64'(o4), 64'hDEAD);
                end else begin
                    e4 = q4.pop_front();
                    chk("u4_result", 64'({z4, ovf4, c4, o4}), 64'(e4));
                end
                del4++;
            end
            if (v4 && rdy4) q4.push_back(model(a4, b4, s4));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (vo1) begin
                if (q1.size() == 0) begin
                    chk("u1_unexpected_result", 64'(o1), 64'hDEAD);
                end else begin
                    e1 = q1.pop_front();
                    chk("u1_result", 64'({z1, ovf1, c1, o1}), 64'(e1));
                end
            end
            if (sw_v && rdy1) q1.push_back(model(sw_a, sw_b, sw_s));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (vo32) begin
                if (q32.size() == 0) begin
                    chk("u32_unexpected_result", 64'(o32), 64'hDEAD);
                end else begin
                    e32 = q32.pop_front();
                    chk("u32_result", 64'({z32, ovf32, c32, o32}), 64'(e32));
                end
            end
            if (sw_v && rdy32) q32.push_back(model(sw_a, sw_b, sw_s));
        end
    end

    // Present one operation to u4 and hold it until an edge accepts it.
    task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic s);
        int   tries;
        logic acc;
        tries = 0;
        acc   = 1'b0;
        v4 = 1'b1; a4 = a; b4 = b; s4 = s;
        do begin
            @(negedge clk);
            acc = rdy4;
            @(posedge clk);
            #1;
            tries++;
        end while (!acc && tries < 50);
        if (!acc) chk("u4_accept_timeout", 64'd0, 64'd1);
        v4 = 1'b0;
    endtask

    // Edges from the accept edge (counted as 1) until out_valid is seen.
    task automatic lat4(output int n);
        n = 1;
        while (!vo4 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain4();
        int n;
        n = 0;
        while (q4.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("u4_drain_left", 64'(q4.size()), 64'd0);
    endtask

    logic [31:0] sa[8];
    logic [31:0] sbv[8];
    logic        ssv[8];
    logic [34:0] held;
    int          n, l1, l32, del_base;

    initial begin
        rst_n = 1'b0;
        v4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; ordy4 = 1'b1;
        sw_v = 1'b0; sw_a = '0; sw_b = '0; sw_s = 1'b0;
        always_ready = 1'b1;

        #1;
        chk("rst_out_valid", 64'(vo4), 64'd0);
        chk("rst_out", 64'(o4), 64'd0);
        chk("rst_flags", 64'({c4, ovf4, z4}), 64'd0);
        chk("rst_in_ready", 64'(rdy4), 64'd1);
        chk("rst_u1_valid", 64'(vo1), 64'd0);
        chk("rst_u32_valid", 64'(vo32), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 5 + 3 with explicit latency and constant result.
        send4(32'h5, 32'h3, 1'b0);
        lat4(n);
        chk("lat_5p3", 64'(n), 64'd4);
        chk("out_5p3", 64'(o4), 64'h8);
        chk("flags_5p3", 64'({c4, ovf4, z4}), 64'd0);

        // Directed boundary vectors, back to back.
        send4(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        send4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        send4(32'h0000_0003, 32'h0000_0005, 1'b1);
        send4(32'h8000_0000, 32'h0000_0001, 1'b1);
        send4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send4(32'h1234_5678, 32'h1234_5678, 1'b1);
        drain4();

        // Eight back-to-back operations with a 3-cycle stall after the first result.
        for (int i = 0; i < 8; i++) begin
            sa[i] = pick(); sbv[i] = pick(); ssv[i] = 1'($urandom_range(0, 1));
        end
        sa[7] = 32'h0000_1234; sbv[7] = 32'h1; ssv[7] = 1'b0;
        del_base = del4;
        for (int i = 0; i < 4; i++) send4(sa[i], sbv[i], ssv[i]);
        chk("stream_first_valid", 64'(vo4), 64'd1);
        held  = model(sa[0], sbv[0], ssv[0]);
        ordy4 = 1'b0;
        v4 = 1'b1; a4 = sa[4]; b4 = sbv[4]; s4 = ssv[4];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(rdy4), 64'd0);
            chk("stall_out_valid", 64'(vo4), 64'd1);
            chk("stall_out_held", 64'({z4, ovf4, c4, o4}), 64'(held));
            @(posedge clk);
            #1;
        end
        ordy4 = 1'b1;
        for (int i = 4; i < 8; i++) send4(sa[i], sbv[i], ssv[i]);
        drain4();
        chk("stream_delivered", 64'(del4 - del_base), 64'd8);

        // Reset two cycles into a pair of in-flight operations.
        send4(32'hAAAA_0001, 32'h0000_0010, 1'b0);
        send4(32'h0000_0100, 32'h0000_0200, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(vo4), 64'd0);
        chk("mid_rst_out", 64'(o4), 64'd0);
        chk("mid_rst_flags", 64'({c4, ovf4, z4}), 64'd0);
        chk("mid_rst_in_ready", 64'(rdy4), 64'd1);
        q4.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 64'(vo4), 64'd0);
            @(posedge clk);
            #1;
        end
        send4(32'h0000_0007, 32'h0000_0009, 1'b1);
        lat4(n);
        chk("post_rst_lat", 64'(n), 64'd4);
        drain4();

        // STAGES=1 and STAGES=32: latency, then a random stream versus the model.
        sw_v = 1'b1; sw_a = 32'h0000_0FFF; sw_b = 32'h0000_0001; sw_s = 1'b0;
        @(posedge clk);
        #1;
        sw_v = 1'b0;
        n = 1; l1 = 0; l32 = 0;
        while ((l1 == 0 || l32 == 0) && n < 60) begin
            if (vo1 && l1 == 0) l1 = n;
            if (vo32 && l32 == 0) l32 = n;
            @(posedge clk);
            #1;
            n++;
        end
        chk("lat_stages1", 64'(l1), 64'd1);
        chk("lat_stages32", 64'(l32), 64'd32);
        for (int i = 0; i < 40; i++) begin
            sw_v = 1'b1; sw_a = pick(); sw_b = pick(); sw_s = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        sw_v = 1'b0;
        n = 0;
        while ((q1.size() != 0 || q32.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("u1_drain_left", 64'(q1.size()), 64'd0);
        chk("u32_drain_left", 64'(q32.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
